// File: rtl/credit_sender_logic.sv
`default_nettype none
// ============================================================================
// Module      : credit_sender_logic
// Description : Producer side of a credit-based latency-insensitive link.
//               Issues registered writes to a remote FIFO while credits
//               remain and recovers credits from a delayed return pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module credit_sender_logic #(
    parameter int DATA_WIDTH     = 16,
    parameter int FIFO_DEPTH     = 8,
    parameter int CREDIT_LATENCY = 1,
    parameter int COUNT_WIDTH    = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  i_data,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [DATA_WIDTH-1:0]  o_data,
    output logic                   o_write_request,
    input  logic                   i_increment_count,
    output logic [COUNT_WIDTH-1:0] o_credit_count,
    output logic                   o_overflow
);

    localparam logic [COUNT_WIDTH-1:0] c_full_count = COUNT_WIDTH'(FIFO_DEPTH);
    localparam logic [COUNT_WIDTH-1:0] c_one        = COUNT_WIDTH'(1);

    logic [COUNT_WIDTH-1:0] r_count;
    logic [DATA_WIDTH-1:0]  r_data;
    logic                   r_write_request;
    logic                   r_overflow;
    logic                   w_send;
    logic                   w_ret;

    // Ready depends only on the counter register, never on i_valid.
    assign o_ready        = (r_count != '0);
    assign w_send         = i_valid && o_ready;
    assign o_data         = r_data;
    assign o_write_request = r_write_request;
    assign o_credit_count = r_count;
    assign o_overflow     = r_overflow;

    generate
        if (CREDIT_LATENCY == 0) begin : g_ret_direct
            assign w_ret = i_increment_count;
        end else begin : g_ret_pipe
            logic [CREDIT_LATENCY-1:0] r_ret_pipe;

            // Reset clears the pipe so in-flight returns are discarded.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_ret_pipe <= '0;
                end else begin
                    r_ret_pipe[0] <= i_increment_count;
                    for (int i = 1; i < CREDIT_LATENCY; i++) begin
                        r_ret_pipe[i] <= r_ret_pipe[i-1];
                    end
                end
            end

            assign w_ret = r_ret_pipe[CREDIT_LATENCY-1];
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_data          <= '0;
            r_write_request <= 1'b0;
        end else begin
            r_write_request <= w_send;
            if (w_send) begin
                r_data <= i_data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count    <= c_full_count;
            r_overflow <= 1'b0;
        end else begin
            if (w_send && !w_ret) begin
                r_count <= r_count - c_one;
            end else if (!w_send && w_ret) begin
                // A return at full means the consumer over-returned credits.
                if (r_count == c_full_count) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_count <= r_count + c_one;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_credit_sender_logic.sv
`default_nettype none
// ============================================================================
// Module      : tb_credit_sender_logic
// Description : Directed vector bench for credit_sender_logic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_credit_sender_logic;

    logic        clock;
    logic        reset;
    logic        reset2;
    logic [15:0] i_data,  i_data2;
    logic        i_valid, i_valid2;
    logic        i_inc,   i_inc2;
    logic        o_ready, o_ready2;
    logic [15:0] o_data,  o_data2;
    logic        o_wr,    o_wr2;
    logic [3:0]  o_cnt,   o_cnt2;
    logic        o_ovf,   o_ovf2;

    int checks   = 0;
    int failures = 0;

    credit_sender_logic #(
        .DATA_WIDTH(16), .FIFO_DEPTH(8), .CREDIT_LATENCY(1)
    ) dut (
        .clock(clock), .reset(reset), .i_data(i_data), .i_valid(i_valid),
        .o_ready(o_ready), .o_data(o_data), .o_write_request(o_wr),
        .i_increment_count(i_inc), .o_credit_count(o_cnt), .o_overflow(o_ovf)
    );

    credit_sender_logic #(
        .DATA_WIDTH(16), .FIFO_DEPTH(8), .CREDIT_LATENCY(2)
    ) dut2 (
        .clock(clock), .reset(reset2), .i_data(i_data2), .i_valid(i_valid2),
        .o_ready(o_ready2), .o_data(o_data2), .o_write_request(o_wr2),
        .i_increment_count(i_inc2), .o_credit_count(o_cnt2), .o_overflow(o_ovf2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        inc;
        logic        wr;
        logic [15:0] od;
        logic [3:0]  cnt;
        logic        rdy;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [15:0] d, input logic inc, input logic wr,
                       input logic [15:0] od, input logic [3:0] cnt, input logic rdy, input logic ovf);
        vec_t t;
        t.v = v; t.d = d; t.inc = inc; t.wr = wr;
        t.od = od; t.cnt = cnt; t.rdy = rdy; t.ovf = ovf;
        vecs.push_back(t);
    endtask

    task automatic chk_main(input string tag, input int idx, input logic wr, input logic [15:0] od,
                            input logic [3:0] cnt, input logic rdy, input logic ovf);
        chk({tag, "_wr"},  idx, 32'(o_wr),    32'(wr));
        chk({tag, "_dat"}, idx, 32'(o_data),  32'(od));
        chk({tag, "_cnt"}, idx, 32'(o_cnt),   32'(cnt));
        chk({tag, "_rdy"}, idx, 32'(o_ready), 32'(rdy));
        chk({tag, "_ovf"}, idx, 32'(o_ovf),   32'(ovf));
    endtask

    initial begin
        // Drain from 8 credits with ten offered items: only eight go out.
        for (int k = 1; k <= 10; k++) begin
            if (k <= 8) add(1'b1, 16'(k), 1'b0, 1'b1, 16'(k), 4'(8 - k), (k != 8), 1'b0);
            else        add(1'b1, 16'(k), 1'b0, 1'b0, 16'h0008, 4'd0, 1'b0, 1'b0);
        end
        // Single return at empty, one-stage return latency.
        add(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0008, 4'd0, 1'b0, 1'b0);
        add(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0008, 4'd1, 1'b1, 1'b0);
        add(1'b1, 16'h0009, 1'b0, 1'b1, 16'h0009, 4'd0, 1'b0, 1'b0);
        add(1'b1, 16'h000A, 1'b0, 1'b0, 16'h0009, 4'd0, 1'b0, 1'b0);
        // Build up to 3 credits, then send and return on the same edge.
        add(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0009, 4'd0, 1'b0, 1'b0);
        add(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0009, 4'd1, 1'b1, 1'b0);
        add(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0009, 4'd2, 1'b1, 1'b0);
        add(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0009, 4'd3, 1'b1, 1'b0);
        add(1'b1, 16'h0033, 1'b0, 1'b1, 16'h0033, 4'd3, 1'b1, 1'b0);
        add(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0033, 4'd3, 1'b1, 1'b0);
        // Refill to 8, then send and return on the same edge at full.
        add(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0033, 4'd3, 1'b1, 1'b0);
        for (int c = 4; c <= 8; c++)
            add(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0033, 4'(c), 1'b1, 1'b0);
        add(1'b1, 16'h0044, 1'b0, 1'b1, 16'h0044, 4'd8, 1'b1, 1'b0);
        add(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0044, 4'd8, 1'b1, 1'b0);
        // Return at full with no send: sticky overflow.
        add(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0044, 4'd8, 1'b1, 1'b0);
        add(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0044, 4'd8, 1'b1, 1'b1);

        reset = 1'b0; reset2 = 1'b0;
        i_data = '0; i_valid = 1'b0; i_inc = 1'b0;
        i_data2 = '0; i_valid2 = 1'b0; i_inc2 = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk_main("rst_hold", 0, 1'b0, 16'h0000, 4'd8, 1'b1, 1'b0);
        reset = 1'b1; reset2 = 1'b1;
        @(posedge clock); #1;
        chk_main("rst_rel", 0, 1'b0, 16'h0000, 4'd8, 1'b1, 1'b0);
        chk("rst_rel_cnt2", 0, 32'(o_cnt2), 32'd8);

        // Reset mid-operation on the two-stage instance.
        i_valid2 = 1'b1; i_data2 = 16'h00A1;
        @(posedge clock); #1;
        i_data2 = 16'h00A2; i_inc2 = 1'b1;
        @(posedge clock); #1;
        i_data2 = 16'h00A3;
        @(posedge clock); #1;
        chk("mid_cnt", 0, 32'(o_cnt2), 32'd5);
        chk("mid_wr",  0, 32'(o_wr2),  32'd1);
        chk("mid_dat", 0, 32'(o_data2), 32'h00A3);
        i_valid2 = 1'b0; i_inc2 = 1'b0;
        reset2 = 1'b0;
        #1;
        chk("async_cnt", 0, 32'(o_cnt2), 32'd8);
        chk("async_wr",  0, 32'(o_wr2),  32'd0);
        chk("async_dat", 0, 32'(o_data2), 32'd0);
        @(posedge clock); #1;
        reset2 = 1'b1;
        @(posedge clock); #1;
        chk("post_rst_cnt", 0, 32'(o_cnt2), 32'd8);
        i_valid2 = 1'b1; i_data2 = 16'h00B1;
        @(posedge clock); #1;
        i_valid2 = 1'b0;
        chk("post_send_cnt", 0, 32'(o_cnt2), 32'd7);
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            chk("inflight_cnt", k, 32'(o_cnt2), 32'd7);
            chk("inflight_ovf", k, 32'(o_ovf2), 32'd0);
        end

        // Table-driven sequence on the single-stage instance.
        for (int i = 0; i < vecs.size(); i++) begin
            i_valid = vecs[i].v;
            i_data  = vecs[i].d;
            i_inc   = vecs[i].inc;
            @(posedge clock); #1;
            chk_main("vec", i, vecs[i].wr, vecs[i].od, vecs[i].cnt, vecs[i].rdy, vecs[i].ovf);
        end
        i_valid = 1'b0; i_inc = 1'b0;

        // Overflow remains set through idle cycles, cleared only by reset.
        for (int k = 0; k < 20; k++) begin
            @(posedge clock); #1;
            chk("ovf_sticky", k, 32'(o_ovf), 32'd1);
        end
        chk("ovf_sticky_cnt", 0, 32'(o_cnt), 32'd8);
        reset = 1'b0;
        #1;
        chk("ovf_clr", 0, 32'(o_ovf), 32'd0);
        chk("ovf_clr_cnt", 0, 32'(o_cnt), 32'd8);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        chk_main("final", 0, 1'b0, 16'h0000, 4'd8, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
